// File: rtl/block_sync_lock_controller.sv
// block_sync_lock_controller: sequences the 100GbE PCS per-lane block-sync array.
//   It gates the array enable, pulses restart to lanes that miss the lock timeout,
//   reports aggregate lock or fail, and counts lock losses.
// Latency: every output is registered, one cycle after the deciding edge.
// Backpressure: none; timers advance only on i_valid cycles, restart pulses count raw clocks.
// Optional macro BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN adds NB_STABLE and i_rf_stable_cycles.
//   When the macro is defined, all lanes must stay locked for that many valid cycles before LOCKED.
// Ports:
//   i_clock, i_reset    : clock and asynchronous active-high reset
//   i_enable, i_signal_ok, i_valid, i_block_lock : control and lane status inputs
//   i_rf_*              : register-file controls (timeout, restart length, retry limit, loss clear)
//   o_sync_enable, o_lane_restart : drive the block-sync array
//   o_all_locked, o_fail, o_state, o_lock_loss_cnt : status outputs to the register file
module block_sync_lock_controller #(
    parameter int N_LANES     = 20,
    parameter int NB_TIMER    = 16,
    parameter int NB_RESTART  = 4,
    parameter int NB_LOSS_CNT = 8,
    parameter int NB_RETRY    = 4
`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
    ,
    parameter int NB_STABLE   = 4
`endif
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic                   i_signal_ok,
    input  logic [N_LANES-1:0]     i_block_lock,
    input  logic [NB_TIMER-1:0]    i_rf_lock_timeout,
    input  logic [NB_RESTART-1:0]  i_rf_restart_len,
    input  logic [NB_RETRY-1:0]    i_rf_max_retry,
    input  logic                   i_rf_clear_loss,
`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
    input  logic [NB_STABLE-1:0]   i_rf_stable_cycles,
`endif
    output logic                   o_sync_enable,
    output logic [N_LANES-1:0]     o_lane_restart,
    output logic                   o_all_locked,
    output logic                   o_fail,
    output logic [2:0]             o_state,
    output logic [NB_LOSS_CNT-1:0] o_lock_loss_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESTART   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [NB_TIMER-1:0]    TIMER_ONE   = NB_TIMER'(1);
    localparam logic [NB_RESTART-1:0]  RESTART_ONE = NB_RESTART'(1);
    localparam logic [NB_RETRY-1:0]    RETRY_ONE   = NB_RETRY'(1);
    localparam logic [NB_LOSS_CNT-1:0] LOSS_ONE    = NB_LOSS_CNT'(1);

    state_t                 state_q;
    logic                   sync_en_q;
    logic [N_LANES-1:0]     restart_mask_q;
    logic                   all_locked_q;
    logic                   fail_q;
    logic [NB_LOSS_CNT-1:0] loss_cnt_q;
    logic [NB_LOSS_CNT-1:0] loss_cnt_d;
    logic [NB_TIMER-1:0]    timer_q;
    logic [NB_RETRY-1:0]    retry_q;
    logic [NB_RESTART-1:0]  restart_cnt_q;

    logic [NB_TIMER-1:0]    timeout_last_d;
    logic [NB_RESTART-1:0]  restart_last_d;
    logic                   all_lock_d;
    logic                   abort_d;
    logic                   timeout_hit_d;
    logic                   enter_lock_d;
    logic                   loss_inc_d;

`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
    localparam logic [NB_STABLE-1:0] STABLE_ONE = NB_STABLE'(1);
    logic [NB_STABLE-1:0]   stable_q;
    logic [NB_STABLE-1:0]   stable_last_d;
`endif

    always_comb begin
        // A programmed value of 0 behaves as 1, so the terminal count is value-1 clamped at 0.
        timeout_last_d = (i_rf_lock_timeout == '0) ? '0 : i_rf_lock_timeout - TIMER_ONE;
        restart_last_d = (i_rf_restart_len == '0) ? '0 : i_rf_restart_len - RESTART_ONE;
        all_lock_d     = &i_block_lock;
        abort_d        = (state_q != ST_IDLE) && (!i_enable || !i_signal_ok);
        timeout_hit_d  = i_valid && (timer_q == timeout_last_d);
`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
        stable_last_d  = (i_rf_stable_cycles == '0) ? '0 : i_rf_stable_cycles - STABLE_ONE;
        enter_lock_d   = all_lock_d && i_valid && (stable_q == stable_last_d);
`else
        enter_lock_d   = all_lock_d;
`endif
        // An abort in the same cycle pre-empts the LOCKED exit, so no loss is recorded.
        loss_inc_d     = (state_q == ST_LOCKED) && !abort_d && !all_lock_d;
        loss_cnt_d     = loss_cnt_q;
        if (i_rf_clear_loss) begin
            loss_cnt_d = '0;
        end else if (loss_inc_d && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + LOSS_ONE;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            sync_en_q      <= 1'b0;
            restart_mask_q <= '0;
            all_locked_q   <= 1'b0;
            fail_q         <= 1'b0;
            loss_cnt_q     <= '0;
            timer_q        <= '0;
            retry_q        <= '0;
            restart_cnt_q  <= '0;
`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
            stable_q       <= '0;
`endif
        end else begin
            loss_cnt_q <= loss_cnt_d;
            if (abort_d) begin
                state_q        <= ST_IDLE;
                sync_en_q      <= 1'b0;
                restart_mask_q <= '0;
                all_locked_q   <= 1'b0;
                fail_q         <= 1'b0;
                timer_q        <= '0;
                retry_q        <= '0;
                restart_cnt_q  <= '0;
`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
                stable_q       <= '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_enable && i_signal_ok) begin
                            state_q        <= ST_RESTART;
                            restart_mask_q <= '1;
                            sync_en_q      <= 1'b1;
                            retry_q        <= '0;
                            restart_cnt_q  <= '0;
                        end
                    end
                    ST_RESTART: begin
                        // Pulse length is in raw clocks; i_valid does not gate it.
                        if (restart_cnt_q == restart_last_d) begin
                            state_q        <= ST_WAIT_LOCK;
                            restart_mask_q <= '0;
                            timer_q        <= '0;
                            restart_cnt_q  <= '0;
`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
                            stable_q       <= '0;
`endif
                        end else begin
                            restart_cnt_q <= restart_cnt_q + RESTART_ONE;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (enter_lock_d) begin
                            state_q      <= ST_LOCKED;
                            all_locked_q <= 1'b1;
                            retry_q      <= '0;
                        end else begin
                            if (timeout_hit_d) begin
                                if (retry_q == i_rf_max_retry) begin
                                    state_q   <= ST_FAIL;
                                    fail_q    <= 1'b1;
                                    sync_en_q <= 1'b0;
                                end else begin
                                    // Only lanes still unlocked get another restart pulse.
                                    state_q        <= ST_RESTART;
                                    retry_q        <= retry_q + RETRY_ONE;
                                    restart_mask_q <= ~i_block_lock;
                                    restart_cnt_q  <= '0;
                                end
                            end else if (i_valid && (timer_q != '1)) begin
                                timer_q <= timer_q + TIMER_ONE;
                            end
`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
                            if (!all_lock_d) begin
                                stable_q <= '0;
                            end else if (i_valid) begin
                                stable_q <= stable_q + STABLE_ONE;
                            end
`endif
                        end
                    end
                    ST_LOCKED: begin
                        // A loss only re-arms the timeout; lanes get a chance to relock unaided.
                        if (!all_lock_d) begin
                            state_q      <= ST_WAIT_LOCK;
                            all_locked_q <= 1'b0;
                            timer_q      <= '0;
`ifdef BLOCK_SYNC_LOCK_CTRL_DEBOUNCE_EN
                            stable_q     <= '0;
`endif
                        end
                    end
                    ST_FAIL: begin
                        // Held until an abort returns the controller to IDLE.
                    end
                    default: begin
                        state_q        <= ST_IDLE;
                        sync_en_q      <= 1'b0;
                        restart_mask_q <= '0;
                        all_locked_q   <= 1'b0;
                        fail_q         <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_sync_enable   = sync_en_q;
    assign o_lane_restart  = restart_mask_q;
    assign o_all_locked    = all_locked_q;
    assign o_fail          = fail_q;
    assign o_state         = state_q;
    assign o_lock_loss_cnt = loss_cnt_q;

endmodule
